// File: rtl/regfile_mp.sv
// Multi-port register file with a three-state register-to-register move engine and a pending scoreboard.
// Optional feature: define REGFILE_BYPASS_EN to forward same-cycle port write data to matching read ports.
module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32,
  parameter int RD_PORTS = 2,
  parameter int WR_PORTS = 2,
  localparam int SEL_W   = $clog2(NUM_REGS)
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic [RD_PORTS*SEL_W-1:0]    i_rd_sel,
  output logic [RD_PORTS*DATA_W-1:0]   o_rd_data,
  input  logic [WR_PORTS-1:0]          i_wr_en,
  input  logic [WR_PORTS*SEL_W-1:0]    i_wr_sel,
  input  logic [WR_PORTS*DATA_W-1:0]   i_wr_data,
  input  logic                         i_mov_valid,
  input  logic [SEL_W-1:0]             i_mov_src,
  input  logic [SEL_W-1:0]             i_mov_dst,
  output logic                         o_mov_ready,
  output logic                         o_mov_done,
  input  logic                         i_busy_set,
  input  logic [SEL_W-1:0]             i_busy_sel,
  output logic [NUM_REGS-1:0]          o_busy
);

  if (NUM_REGS < 4 || (NUM_REGS & (NUM_REGS - 1)) != 0) begin : g_bad_num_regs
    $error("regfile_mp: NUM_REGS must be a power of two and at least 4");
  end
  if (RD_PORTS < 1 || RD_PORTS > 4) begin : g_bad_rd_ports
    $error("regfile_mp: RD_PORTS must be 1 to 4");
  end
  if (WR_PORTS < 1 || WR_PORTS > 4) begin : g_bad_wr_ports
    $error("regfile_mp: WR_PORTS must be 1 to 4");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2
  } mov_state_t;

  mov_state_t state, state_next;

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic [SEL_W-1:0]  rd_sel  [RD_PORTS];
  logic [DATA_W-1:0] rd_data [RD_PORTS];
  logic [SEL_W-1:0]  wr_sel  [WR_PORTS];
  logic [DATA_W-1:0] wr_data [WR_PORTS];

  logic [SEL_W-1:0]    src_q;
  logic [SEL_W-1:0]    dst_q;
  logic [DATA_W-1:0]   val_q;
  logic                done_q;
  logic                mov_ready;
  logic                mov_commit;
  logic [NUM_REGS-1:0] busy;
  logic [NUM_REGS-1:0] write_hit;

  for (genvar p = 0; p < RD_PORTS; p++) begin : g_rd_unpack
    assign rd_sel[p]                        = i_rd_sel[p*SEL_W +: SEL_W];
    assign o_rd_data[p*DATA_W +: DATA_W]    = rd_data[p];
  end

  for (genvar p = 0; p < WR_PORTS; p++) begin : g_wr_unpack
    assign wr_sel[p]  = i_wr_sel[p*SEL_W +: SEL_W];
    assign wr_data[p] = i_wr_data[p*DATA_W +: DATA_W];
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (i_mov_valid) state_next = READ;
      READ:    state_next = WRITE;
      WRITE:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    mov_ready  = 1'b0;
    mov_commit = 1'b0;
    case (state)
      IDLE:    mov_ready  = 1'b1;
      WRITE:   mov_commit = 1'b1;
      default: ;
    endcase
  end

  // Done is registered off the WRITE cycle, so it appears three cycles after the accepting cycle.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      src_q  <= '0;
      dst_q  <= '0;
      val_q  <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= mov_commit;
      if (mov_ready && i_mov_valid) begin
        src_q <= i_mov_src;
        dst_q <= i_mov_dst;
      end
      if (state == READ) begin
        val_q <= regs[src_q];
      end
    end
  end

  // Move write goes first so any port write to the same register overrides it; higher ports override lower.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        regs[r] <= '0;
      end
    end else begin
      if (mov_commit) begin
        regs[dst_q] <= val_q;
      end
      for (int p = 0; p < WR_PORTS; p++) begin
        if (i_wr_en[p]) begin
          regs[wr_sel[p]] <= wr_data[p];
        end
      end
    end
  end

  always_comb begin
    write_hit = '0;
    if (mov_commit) begin
      write_hit[dst_q] = 1'b1;
    end
    for (int p = 0; p < WR_PORTS; p++) begin
      if (i_wr_en[p]) begin
        write_hit[wr_sel[p]] = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      busy <= '0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        if (write_hit[r]) begin
          busy[r] <= 1'b0;
        end
      end
      if (i_busy_set) begin
        busy[i_busy_sel] <= 1'b1;
      end
    end
  end

  always_comb begin
    for (int q = 0; q < RD_PORTS; q++) begin
      rd_data[q] = regs[rd_sel[q]];
`ifdef REGFILE_BYPASS_EN
      for (int p = 0; p < WR_PORTS; p++) begin
        if (i_wr_en[p] && wr_sel[p] == rd_sel[q]) begin
          rd_data[q] = wr_data[p];
        end
      end
`endif
    end
  end

  assign o_mov_ready = mov_ready;
  assign o_mov_done  = done_q;
  assign o_busy      = busy;

endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 SHALL have parameter DATA_W, default 32: register width in bits.
REQ-002 SHALL have parameter NUM_REGS, default 32: register count, a power of two and at least 4; SEL_W = clog2(NUM_REGS).
REQ-003 SHALL have parameter RD_PORTS, default 2: number of read ports, 1 to 4.
REQ-004 SHALL have parameter WR_PORTS, default 2: number of write ports, 1 to 4.
REQ-005 SHALL have: i_clk  in  1  single clock; all state updates on its rising edge.
REQ-006 SHALL have: i_rst  in  1  reset, asynchronous, active-high.
REQ-007 SHALL have: i_rd_sel  in  RD_PORTS*SEL_W  read select; port p uses slice p.
REQ-008 SHALL have: o_rd_data  out  RD_PORTS*DATA_W  read data for each port.
REQ-009 SHALL have: i_wr_en  in  WR_PORTS  per-port write enable.
REQ-010 SHALL have: i_wr_sel  in  WR_PORTS*SEL_W  write select for each port.
REQ-011 SHALL have: i_wr_data  in  WR_PORTS*DATA_W  write data for each port.
REQ-012 SHALL have: i_mov_valid  in  1  register-to-register move request.
REQ-013 SHALL have: i_mov_src, i_mov_dst  in  SEL_W each  move source and destination.
REQ-014 SHALL have: o_mov_ready  out  1  move engine accepts a request.
REQ-015 SHALL have: o_mov_done  out  1  one-cycle pulse when a move retires.
REQ-016 SHALL have: i_busy_set  in  1  with i_busy_sel (in, SEL_W); marks a register pending.
REQ-017 SHALL have: o_busy  out  NUM_REGS  per-register pending scoreboard.

Function
REQ-018 SHALL drive each o_rd_data slice combinationally from the register at its select; there are no tristate outputs.
REQ-019 SHALL apply each enabled write port at the clock edge; when several ports target one register, the highest-index port SHALL win.
REQ-020 SHALL run the move engine as an FSM with states IDLE, READ and WRITE.
- o_mov_ready is 1 only in IDLE.
- i_mov_valid high in IDLE latches i_mov_src and i_mov_dst, then goes to READ.
REQ-021 In READ, the engine SHALL latch the stored value of the source register, then go to WRITE.
REQ-022 In WRITE, the engine SHALL write the latched value to the destination, pulse o_mov_done, and return to IDLE.
- Request-to-done latency is 3 cycles.
REQ-023 If any enabled port targets the move destination in the WRITE cycle, the port write SHALL win, the move write SHALL be dropped, and o_mov_done SHALL still pulse.
REQ-024 A move with src equal to dst SHALL complete normally with the register unchanged, apart from any port write.
REQ-025 i_busy_set SHALL set o_busy[i_busy_sel]; any write to a register (port or move) SHALL clear its bit.
REQ-026 If a set and a clear hit the same register in one cycle, the set SHALL win.
REQ-027 Out-of-range selects cannot occur, because NUM_REGS is a power of two.

Reset
REQ-028 While i_rst is high, all of the following SHALL hold immediately, without waiting for a clock:
- all registers, the latched move operands and o_busy are 0;
- the FSM is in IDLE, o_mov_ready is 1 and o_mov_done is 0.
REQ-029 Reset asserted mid-move SHALL abort the move with no destination write and no o_mov_done pulse.

Configuration
REQ-030 With REGFILE_BYPASS_EN defined, a read port whose select matches an enabled write port SHALL return the winning port's i_wr_data in the same cycle; move writes are not bypassed.
REQ-031 Without REGFILE_BYPASS_EN, read ports SHALL return only stored values; new data is visible the cycle after the write.

Verification
REQ-032 Reset, then read r0..r31 -> all 0; o_busy = 0; o_mov_ready = 1.
REQ-033 Same cycle: port0 writes r5=0x11111111 and port1 writes r5=0x22222222 -> next cycle r5 reads 0x22222222.
REQ-034 Write r3=0xDEADBEEF, then move src=3, dst=9 -> o_mov_done pulses 3 cycles after accept; r9 = 0xDEADBEEF; o_mov_ready is low for 2 cycles.
REQ-035 Move src=1, dst=7 while port0 writes r7=0xA5A5A5A5 in the WRITE cycle -> r7 = 0xA5A5A5A5; o_mov_done pulses.
REQ-036 busy_set r4, write r4 -> o_busy[4] = 0; then busy_set r4 plus write r4 in the same cycle -> o_busy[4] = 1.
REQ-037 Read r6 while port0 writes r6=0x12345678 -> with REGFILE_BYPASS_EN, reads 0x12345678 the same cycle; without it, reads the old value, then 0x12345678 the next cycle.
